// File: rtl/mch3d_pkg.sv
// Record format shared by the command decoder and the triangle serializer.
package mch3d_pkg;
  localparam int TRI_BYTES = 60;
  localparam int TRI_W     = 8 * TRI_BYTES;
endpackage

// File: rtl/triangle_serializer.sv
// Pops 480-bit triangle records and streams them MSB byte first into a byte FIFO,
// matching the byte order the command decoder reassembles.
module triangle_serializer
  import mch3d_pkg::*;
#(
  parameter int BYTES = TRI_BYTES,
  parameter int DW    = 8 * BYTES,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] tri_rddata,
  input  logic          tri_empty,
  output logic          tri_pull,
  input  logic          byte_full,
  output logic [7:0]    byte_wrdata,
  output logic          byte_push,
  output logic          busy,
  output logic [CW-1:0] tri_count
);

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   shreg;
  logic [IW-1:0]   idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      tri_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          shreg <= tri_rddata;
          idx   <= '0;
        end
        SEND: begin
          if (byte_push) begin
            shreg <= shreg << 8;
            idx   <= idx + 1'b1;
            if (idx == LAST) tri_count <= tri_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The final-byte push and the next pull share a cycle so records run back to back.
  always_comb begin
    state_nxt = state;
    tri_pull  = 1'b0;
    byte_push = 1'b0;
    case (state)
      IDLE: begin
        if (!tri_empty) begin
          tri_pull  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (!byte_full) begin
          byte_push = 1'b1;
          if (idx == LAST) begin
            if (!tri_empty) begin
              tri_pull  = 1'b1;
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Strobes stay quiet while reset is held, even if the FIFO has data waiting.
    if (rst) begin
      tri_pull  = 1'b0;
      byte_push = 1'b0;
    end
  end

  assign byte_wrdata = shreg[DW-1 -: 8];
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_triangle_serializer.sv
// Bench for triangle_serializer: emulated triangle FIFO, byte-stream model and
// directed scenarios covering latency, back-to-back, back-pressure, reset and loopback.
module tb_triangle_serializer;
  import mch3d_pkg::*;

  localparam int BYTES = TRI_BYTES;
  localparam int DW    = TRI_W;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tri_rddata = '0;
  logic          tri_empty;
  logic          tri_pull;
  logic          byte_full;
  logic [7:0]    byte_wrdata;
  logic          byte_push;
  logic          busy;
  logic [CW-1:0] tri_count;

  always #5 clk = ~clk;

  triangle_serializer #(.BYTES(BYTES), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tri_rddata (tri_rddata),
    .tri_empty  (tri_empty),
    .tri_pull   (tri_pull),
    .byte_full  (byte_full),
    .byte_wrdata(byte_wrdata),
    .byte_push  (byte_push),
    .busy       (busy),
    .tri_count  (tri_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Triangle FIFO emulation: data appears the cycle after the pull.
  logic [DW-1:0] src_q[$];
  int pushed_n = 0;
  int popped_n = 0;
  assign tri_empty = (pushed_n == popped_n);

  always @(posedge clk) begin
    if (tri_pull && src_q.size() > 0) begin
      tri_rddata <= src_q.pop_front();
      popped_n   <= popped_n + 1;
    end
  end

  // Model: the byte stream is every queued record, MSB byte first, in order.
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int model_cnt = 0;
  int rec_bytes = 0;

  task automatic push_rec(input logic [DW-1:0] r);
    src_q.push_back(r);
    for (int k = 0; k < BYTES; k++) exp_q.push_back(r[DW-1-8*k -: 8]);
    pushed_n++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", {tri_pull, byte_push, busy, byte_wrdata}, 64'd0);
      chk("rst_tri_count", tri_count, 64'd0);
      exp_q.delete();
      model_cnt = 0;
      rec_bytes = 0;
    end else begin
      chk("tri_count", tri_count, model_cnt);
      if (tri_pull) chk("pull_when_empty", tri_empty, 64'd0);
      if (byte_push) begin
        chk("push_while_full", byte_full, 64'd0);
        if (exp_q.size() == 0) chk("unexpected_push", 64'd1, 64'd0);
        else chk("byte", byte_wrdata, exp_q.pop_front());
        cap_q.push_back(byte_wrdata);
        rec_bytes++;
        if (rec_bytes == BYTES) begin
          rec_bytes = 0;
          model_cnt = (model_cnt + 1) % (1 << CW);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    byte_full = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
  endtask

  logic [DW-1:0] rec_a, rec_f, rec_aa, rec_55, rec;
  logic [DW-1:0] lb_src[8];

  initial begin
    int first, last, npush, npull, stalls, bubbles, burst;
    bit bdone;
    rst       = 1'b1;
    byte_full = 1'b0;
    for (int k = 0; k < BYTES; k++) begin
      rec_a[DW-1-8*k -: 8] = 8'(k + 1);
      rec_f[DW-1-8*k -: 8] = 8'(8'hF0 + k);
      rec_aa[DW-1-8*k -: 8] = 8'hAA;
      rec_55[DW-1-8*k -: 8] = 8'h55;
    end
    do_reset();

    // Single record, free-running sink
    push_rec(rec_a);
    first = -1; last = -1; npush = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 0) chk("t1_pull_c0", tri_pull, 64'd1);
      if (c == 1) chk("t1_load_c1", {busy, byte_push, tri_pull}, 64'b100);
      if (c == 2) chk("t1_first_byte", {byte_push, byte_wrdata}, {1'b1, 8'h01});
      if (c == 61) chk("t1_last_byte", {byte_push, busy, byte_wrdata}, {2'b11, 8'h3C});
      if (c == 62) chk("t1_busy_c62", busy, 64'd0);
      if (byte_push) begin
        if (first < 0) first = c;
        last = c;
        npush++;
      end
      cyc();
    end
    chk("t1_first_cycle", first, 64'd2);
    chk("t1_last_cycle", last, 64'd61);
    chk("t1_npush", npush, 64'd60);
    chk("t1_tri_count", tri_count, 64'd1);

    // Back-to-back records
    do_reset();
    push_rec(rec_aa);
    push_rec(rec_55);
    npull = 0; npush = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (tri_pull) npull++;
      if (byte_push) npush++;
      if (c == 61) chk("t2_pull_with_last_aa", {tri_pull, byte_push, byte_wrdata}, {2'b11, 8'hAA});
      if (c == 62) chk("t2_gap", {busy, byte_push}, 64'b10);
      if (c == 63) chk("t2_first_55", {byte_push, byte_wrdata}, {1'b1, 8'h55});
      if (c == 122) chk("t2_last_55", {byte_push, byte_wrdata}, {1'b1, 8'h55});
      if (c == 123) chk("t2_idle_after", busy, 64'd0);
      cyc();
    end
    chk("t2_npull", npull, 64'd2);
    chk("t2_npush", npush, 64'd120);
    chk("t2_tri_count", tri_count, 64'd2);

    // Back-pressure: alternating full with a 10-cycle burst before byte 30
    do_reset();
    push_rec(rec_a);
    first = -1; last = -1; npush = 0; stalls = 0; bubbles = 0; burst = 0; bdone = 0;
    for (int c = 0; c < 400 && npush < 60; c++) begin
      if (!bdone && npush == 30) begin
        burst = 10;
        bdone = 1;
      end
      if (burst > 0) begin
        byte_full = 1'b1;
        burst--;
      end else begin
        byte_full = (c % 2) != 0;
      end
      @(negedge clk);
      if (byte_push) begin
        if (first < 0) first = c;
        last = c;
        npush++;
      end else if (first >= 0) begin
        if (byte_full) stalls++;
        else bubbles++;
      end
      cyc();
    end
    byte_full = 1'b0;
    cyc();
    chk("t3_npush", npush, 64'd60);
    chk("t3_span", last - first + 1, 64'(60 + stalls));
    chk("t3_bubbles", bubbles, 64'd0);
    chk("t3_burst_seen", stalls >= 10, 64'd1);
    chk("t3_tri_count", tri_count, 64'd1);

    // Reset mid-record
    do_reset();
    push_rec(rec_a);
    npush = 0;
    for (int c = 0; c < 100 && npush < 20; c++) begin
      @(negedge clk);
      if (byte_push) npush++;
      cyc();
    end
    chk("t4_reached_20", npush, 64'd20);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_outputs_in_rst", {tri_pull, byte_push, busy, byte_wrdata, tri_count}, 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("t4_idle_after_rst", {busy, tri_count}, 64'd0);
    cyc();
    push_rec(rec_f);
    first = -1; npush = 0;
    for (int c = 0; c < 100 && npush < 60; c++) begin
      @(negedge clk);
      if (byte_push) begin
        if (first < 0) begin
          first = c;
          chk("t4_first_byte_f0", byte_wrdata, 64'hF0);
          chk("t4_count_before", tri_count, 64'd0);
        end
        npush++;
      end
      cyc();
    end
    cyc();
    chk("t4_first_cycle", first, 64'd2);
    chk("t4_tri_count", tri_count, 64'd1);

    // Idle with empty FIFO
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("t5_idle", {tri_pull, byte_push, busy}, 64'd0);
      cyc();
    end

    // Loopback: rebuild records from the captured byte stream
    do_reset();
    cap_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < DW / 32; w++) lb_src[r][32*w +: 32] = $urandom;
      push_rec(lb_src[r]);
    end
    for (int c = 0; c < 3000 && cap_q.size() < 8 * BYTES; c++) begin
      byte_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc();
    end
    byte_full = 1'b0;
    cyc();
    chk("t6_nbytes", cap_q.size(), 64'(8 * BYTES));
    chk("t6_tri_count", tri_count, 64'd8);
    if (cap_q.size() == 8 * BYTES) begin
      for (int r = 0; r < 8; r++) begin
        rec = '0;
        for (int k = 0; k < BYTES; k++) rec = {rec[DW-9:0], cap_q[r*BYTES+k]};
        chk($sformatf("t6_record%0d", r), rec == lb_src[r], 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
